matrix_loader: RTL and testbench

//  Upstream feeder for the NxN matrix multiplier. Accepts a serial valid/ready element stream,

---
 rtl/matrix_loader_if.sv | 28 ++
 rtl/matrix_loader.sv | 148 ++++++++++++++
 tb/tb_matrix_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_loader_if.sv
// Stream and operand bus between an element source and matrix_loader.
// Handshake: an element transfers on a rising clk edge where s_valid and
// s_ready are both high. The source holds s_data/s_last stable while
// s_valid is high and s_ready is low. s_ready never depends on s_valid.
interface matrix_loader_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16
);
  logic                             s_valid;
  logic                             s_ready;
  logic [WIDTH-1:0]                 s_data;
  logic                             s_last;
  logic [N-1:0][N-1:0][WIDTH-1:0]   A;
  logic [N-1:0][N-1:0][WIDTH-1:0]   B;
  logic                             mat_valid;
  logic                             c_capture;
  logic                             err_frame;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, A, B, mat_valid, c_capture, err_frame
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, A, B, mat_valid, c_capture, err_frame
  );
endinterface

// File: rtl/matrix_loader.sv
// matrix_loader: assembles operand matrices A then B from a serial element
// stream, holds them on parallel outputs for the multiplier latency and
// pulses c_capture in the cycle the multiplier's C reflects them.
// Optional build macro MATRIX_LOADER_BCOLMAJOR_EN: the B stream arrives
// column-major and is stored transposed; A is always row-major.
// o_dbg_state exposes the FSM state (0 IDLE, 1 LOAD_A, 2 LOAD_B, 3 HOLD).
module matrix_loader #(
  parameter int N           = 4,
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2,
  parameter int HOLD_CYCLES = PIPE_STAGES + N + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  matrix_loader_if.slave    bus,
  output logic [1:0]        o_dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_A = 2'd1,
    S_LOAD_B = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                          r_state;
  logic [CW-1:0]                   r_row;
  logic [CW-1:0]                   r_col;
  logic [HW-1:0]                   r_hold;
  logic [N-1:0][N-1:0][WIDTH-1:0]  r_a;
  logic [N-1:0][N-1:0][WIDTH-1:0]  r_b;
  logic                            r_mat_valid;
  logic                            r_c_capture;
  logic                            r_err_frame;

  logic                            w_xfer;
  logic                            w_final;

  // Ready is a pure decode of the state register, never of s_valid.
  assign bus.s_ready  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_xfer       = bus.s_valid && bus.s_ready;
  assign w_final      = (r_row == LAST_IDX) && (r_col == LAST_IDX);

  assign bus.A         = r_a;
  assign bus.B         = r_b;
  assign bus.mat_valid = r_mat_valid;
  assign bus.c_capture = r_c_capture;
  assign bus.err_frame = r_err_frame;
  assign o_dbg_state   = r_state;

  // Frame FSM: element placement, framing checks, hold countdown and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_hold      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_mat_valid <= 1'b0;
      r_c_capture <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_err_frame <= 1'b0;
      r_c_capture <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_LOAD_A;
        end

        S_LOAD_A: begin
          if (w_xfer) begin
            if (bus.s_last) begin
              // s_last is never legal inside A: drop element, restart frame.
              r_err_frame <= 1'b1;
              r_row       <= '0;
              r_col       <= '0;
            end else begin
              r_a[r_row][r_col] <= bus.s_data;
              if (w_final) begin
                r_row   <= '0;
                r_col   <= '0;
                r_state <= S_LOAD_B;
              end else if (r_col == LAST_IDX) begin
                r_col <= '0;
                r_row <= r_row + CW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end

        S_LOAD_B: begin
          if (w_xfer) begin
            if (bus.s_last != w_final) begin
              // s_last must mark exactly the final B element.
              r_err_frame <= 1'b1;
              r_row       <= '0;
              r_col       <= '0;
              r_state     <= S_LOAD_A;
            end else begin
`ifdef MATRIX_LOADER_BCOLMAJOR_EN
              r_b[r_col][r_row] <= bus.s_data;
`else
              r_b[r_row][r_col] <= bus.s_data;
`endif
              if (w_final) begin
                r_row       <= '0;
                r_col       <= '0;
                r_hold      <= HW'(HOLD_CYCLES);
                r_mat_valid <= 1'b1;
                r_c_capture <= (HOLD_CYCLES == 0);
                r_state     <= S_HOLD;
              end else if (r_col == LAST_IDX) begin
                r_col <= '0;
                r_row <= r_row + CW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end

        S_HOLD: begin
          // c_capture lands on the cycle the counter reads zero, which is
          // also the final cycle of mat_valid.
          if (r_hold == '0) begin
            r_mat_valid <= 1'b0;
            r_state     <= S_LOAD_A;
          end else begin
            r_hold      <= r_hold - HW'(1);
            r_c_capture <= (r_hold == HW'(1));
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: randomized element streams, a
// frame-level reference model and an event scoreboard checked by a monitor.
`timescale 1ns/1ps
module tb_matrix_loader;

  localparam int N           = 4;
  localparam int WIDTH       = 16;
  localparam int PIPE_STAGES = 2;
  localparam int HOLD_CYCLES = PIPE_STAGES + N + 1;
  localparam int NE          = N * N;
  localparam logic [1:0] K_FRAME = 2'd0;
  localparam logic [1:0] K_ERR   = 2'd1;

  typedef logic [N-1:0][N-1:0][WIDTH-1:0] mat_t;
  typedef logic [N-1:0][N-1:0][63:0]      cmat_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  matrix_loader_if #(.N(N), .WIDTH(WIDTH)) bus ();

  matrix_loader #(
    .N(N), .WIDTH(WIDTH), .PIPE_STAGES(PIPE_STAGES), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cmat_t matmul(input mat_t a, input mat_t b);
    cmat_t c;
    c = '0;
    for (int r = 0; r < N; r++)
      for (int cc = 0; cc < N; cc++)
        for (int k = 0; k < N; k++)
          c[r][cc] = c[r][cc] + 64'(a[r][k]) * 64'(b[k][cc]);
    return c;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [1:0] exp_kind_q[$];
  mat_t       exp_a_q[$];
  mat_t       exp_b_q[$];
  cmat_t      exp_c_q[$];
  mat_t       m_a, m_b;
  int         m_pos;

  task automatic model_reset();
    m_a = '0; m_b = '0; m_pos = 0;
    exp_kind_q.delete(); exp_a_q.delete(); exp_b_q.delete(); exp_c_q.delete();
  endtask

  task automatic sb_push(input logic [1:0] kind);
    exp_kind_q.push_back(kind);
    exp_a_q.push_back(m_a);
    exp_b_q.push_back(m_b);
    exp_c_q.push_back(matmul(m_a, m_b));
  endtask

  // Frame position p runs over 2*N*N accepted elements; only p == last may carry s_last.
  task automatic model_accept(input logic [WIDTH-1:0] d, input logic l);
    int k;
    k = m_pos;
    if (l != (k == 2 * NE - 1)) begin
      sb_push(K_ERR);
      m_pos = 0;
      return;
    end
    if (k < NE) m_a[k / N][k % N] = d;
    else begin
`ifdef MATRIX_LOADER_BCOLMAJOR_EN
      m_b[(k - NE) % N][(k - NE) / N] = d;
`else
      m_b[(k - NE) / N][(k - NE) % N] = d;
`endif
    end
    m_pos = k + 1;
    if (m_pos == 2 * NE) begin
      sb_push(K_FRAME);
      m_pos = 0;
    end
  endtask

  // ---------------- monitor ----------------
  logic  prev_mv = 1'b0;
  int    hold_cyc = 0;
  int    cap_cyc = -1;
  int    cap_count = 0;
  cmat_t cur_c;

  task automatic sb_pop(input logic [1:0] kind, input string name);
    check({name, "_pending"}, 1024'(exp_kind_q.size() > 0), 1024'(1'b1));
    if (exp_kind_q.size() > 0) begin
      check({name, "_kind"}, 1024'(exp_kind_q.pop_front()), 1024'(kind));
      if (kind == K_FRAME) begin
        check("frame_A", 1024'(bus.A), 1024'(exp_a_q.pop_front()));
        check("frame_B", 1024'(bus.B), 1024'(exp_b_q.pop_front()));
        cur_c = exp_c_q.pop_front();
      end else begin
        void'(exp_a_q.pop_front());
        void'(exp_b_q.pop_front());
        void'(exp_c_q.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mv  = 1'b0;
      hold_cyc = 0;
      cap_cyc  = -1;
    end else begin
      if (bus.err_frame) sb_pop(K_ERR, "err_frame");
      if (bus.mat_valid) begin
        if (!prev_mv) begin
          sb_pop(K_FRAME, "mat_valid");
          hold_cyc = 0;
          cap_cyc  = -1;
        end else begin
          hold_cyc++;
        end
        check("s_ready_in_hold", 1024'(bus.s_ready), 1024'(1'b0));
        if (bus.c_capture) begin
          cap_cyc = hold_cyc;
          cap_count++;
          check("capture_cycle", 1024'(hold_cyc), 1024'(HOLD_CYCLES));
          check("captured_C", 1024'(matmul(bus.A, bus.B)), 1024'(cur_c));
        end
      end else begin
        if (prev_mv) begin
          check("hold_len", 1024'(hold_cyc), 1024'(HOLD_CYCLES));
          check("capture_seen", 1024'(cap_cyc), 1024'(HOLD_CYCLES));
        end
        check("c_capture_outside_hold", 1024'(bus.c_capture), 1024'(1'b0));
      end
      prev_mv = bus.mat_valid;
    end
  end

  // ---------------- driver tasks ----------------
  logic [WIDTH-1:0] fa[NE];
  logic [WIDTH-1:0] fb[NE];

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int budget;
    budget = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
    while (!bus.s_ready && budget < 100) begin cycles(1); budget++; end
    check("send_ready_wait", 1024'(bus.s_ready), 1024'(1'b1));
    if (!bus.s_ready) begin bus.s_valid = 1'b0; return; end
    cycles(1);
    bus.s_valid = 1'b0;
    model_accept(d, l);
  endtask

  task automatic send_frame(input int gap_pct);
    for (int i = 0; i < 2 * NE; i++) begin
      if ($urandom_range(0, 99) < gap_pct) cycles($urandom_range(1, 3));
      send((i < NE) ? fa[i] : fb[i - NE], i == 2 * NE - 1);
    end
  endtask

  task automatic wait_ready();
    int budget;
    budget = 0;
    while (!bus.s_ready && budget < 60) begin cycles(1); budget++; end
    check("wait_ready", 1024'(bus.s_ready), 1024'(1'b1));
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < NE; i++) begin
      fa[i] = WIDTH'($urandom_range(0, 65535));
      fb[i] = WIDTH'($urandom_range(0, 65535));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mat_valid"}, 1024'(bus.mat_valid), 1024'(1'b0));
    check({tag, "_c_capture"}, 1024'(bus.c_capture), 1024'(1'b0));
    check({tag, "_err_frame"}, 1024'(bus.err_frame), 1024'(1'b0));
    check({tag, "_s_ready"},   1024'(bus.s_ready),   1024'(1'b0));
    check({tag, "_A"}, 1024'(bus.A), 1024'(0));
    check({tag, "_B"}, 1024'(bus.B), 1024'(0));
    check({tag, "_state"}, 1024'(dbg_state), 1024'(2'd0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int   caps_before;
  cmat_t exp_c;

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk); rst_n = 1'b1; #1;
    check("release_idle", 1024'(dbg_state), 1024'(2'd0));
    cycles(1);
    check("release_load_a", 1024'(dbg_state), 1024'(2'd1));
    check("release_s_ready", 1024'(bus.s_ready), 1024'(1'b1));

    // Test 1: A = 1..16, B = identity; C must equal A.
    for (int i = 0; i < NE; i++) begin
      fa[i] = WIDTH'(i + 1);
      fb[i] = (i / N == i % N) ? WIDTH'(1) : WIDTH'(0);
    end
    send_frame(0);
    check("t1_mat_valid_rise", 1024'(bus.mat_valid), 1024'(1'b1));
    check("t1_s_ready_low", 1024'(bus.s_ready), 1024'(1'b0));
    exp_c = '0;
    for (int i = 0; i < NE; i++) exp_c[i / N][i % N] = 64'(i + 1);
    check("t1_c_equals_a", 1024'(matmul(bus.A, bus.B)), 1024'(exp_c));
    wait_ready();

    // Test 2: random data with ~50% s_valid gaps.
    for (int f = 0; f < 3; f++) begin
      randomize_frame();
      send_frame(50);
      wait_ready();
    end

    // Test 3: s_last on A element 5, then a clean frame.
    randomize_frame();
    for (int i = 0; i < 5; i++) send(fa[i], 1'b0);
    send(fa[5], 1'b1);
    check("t3_err_pulse", 1024'(bus.err_frame), 1024'(1'b1));
    cycles(1);
    check("t3_err_single", 1024'(bus.err_frame), 1024'(1'b0));
    randomize_frame();
    send_frame(20);
    wait_ready();

    // Test 4: final B element without s_last.
    randomize_frame();
    for (int i = 0; i < 2 * NE - 1; i++) send((i < NE) ? fa[i] : fb[i - NE], 1'b0);
    send(fb[NE - 1], 1'b0);
    check("t4_err_pulse", 1024'(bus.err_frame), 1024'(1'b1));
    check("t4_state_load_a", 1024'(dbg_state), 1024'(2'd1));
    cycles(HOLD_CYCLES + 2);
    check("t4_no_mat_valid", 1024'(bus.mat_valid), 1024'(1'b0));

    // Test 5: reset during the third HOLD cycle.
    randomize_frame();
    send_frame(0);
    caps_before = cap_count;
    cycles(2);
    #2 rst_n = 1'b0; model_reset();
    #1;
    check_zero_outputs("t5_reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    check("t5_idle", 1024'(dbg_state), 1024'(2'd0));
    cycles(1);
    check("t5_load_a", 1024'(dbg_state), 1024'(2'd1));
    check("t5_no_capture", 1024'(cap_count), 1024'(caps_before));

`ifdef MATRIX_LOADER_BCOLMAJOR_EN
    // Test 6: column-major B stream 1..16.
    randomize_frame();
    for (int i = 0; i < NE; i++) fb[i] = WIDTH'(i + 1);
    send_frame(0);
    check("t6_b01", 1024'(bus.B[0][1]), 1024'(5));
    check("t6_b10", 1024'(bus.B[1][0]), 1024'(2));
    wait_ready();
`endif

    // Closing random frame with gaps.
    randomize_frame();
    send_frame(30);
    wait_ready();
    cycles(3);
    check("scoreboard_drained", 1024'(exp_kind_q.size()), 1024'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
